// File: rtl/lfsr_fib_checker.sv
// Self-synchronising receive checker for a Fibonacci LFSR bit stream.
// Hunts by loading received bits, locks after a run of correct predictions, then counts errors.
module lfsr_fib_checker #(
  parameter int unsigned          LN       = 8,
  parameter logic [LN-1:0]        TAPS     = 8'h2D,
  parameter int unsigned          LOCK_CNT = 16,
  parameter int unsigned          LOSS_CNT = 4,
  parameter int unsigned          ERRW     = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        shiftBit__ENA,
  input  logic                        shiftBit_v,
  output logic                        shiftBit__RDY,
  input  logic                        clearErr__ENA,
  output logic                        clearErr__RDY,
  output logic                        locked,
  output logic [ERRW-1:0]             errCount,
  output logic [$clog2(LN+1)-1:0]     fillCount
);

  localparam int unsigned FW = $clog2(LN + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  localparam logic [FW-1:0]   FILL_FULL = FW'(LN);
  localparam logic [MW-1:0]   MATCH_M1  = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0]   MISS_M1   = LW'(LOSS_CNT - 1);
  localparam logic [ERRW-1:0] ERR_ZERO  = {ERRW{1'b0}};
  localparam logic [ERRW-1:0] ERR_MAX   = {ERRW{1'b1}};

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } fsm_e;

  function automatic logic pred_bit(input logic [LN-1:0] s);
    return ^(s & TAPS);
  endfunction

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
    if (c == ERR_MAX) begin
      return c;
    end else begin
      return c + {{(ERRW-1){1'b0}}, 1'b1};
    end
  endfunction

  fsm_e            fsm_q, fsm_d;
  logic [LN-1:0]   lfsr_q, lfsr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [MW-1:0]   match_q, match_d;
  logic [LW-1:0]   miss_q, miss_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            locked_q, locked_d;
  logic            pred_s;
  logic [ERRW-1:0] err_base_s;

  // Next-state: hunt loads received bits, lock free-runs the predictor; clear applies before counting
  always_comb begin
    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    fill_d     = fill_q;
    match_d    = match_q;
    miss_d     = miss_q;
    locked_d   = locked_q;
    pred_s     = pred_bit(lfsr_q);
    if (clearErr__ENA) begin
      err_base_s = ERR_ZERO;
    end else begin
      err_base_s = err_q;
    end
    err_d = err_base_s;

    if (shiftBit__ENA) begin
      case (fsm_q)
        HUNT: begin
          lfsr_d = {lfsr_q[LN-2:0], shiftBit_v};
          if (fill_q == FILL_FULL) begin
            if (shiftBit_v == pred_s) begin
              if (match_q == MATCH_M1) begin
                fsm_d    = LOCK;
                locked_d = 1'b1;
                match_d  = {MW{1'b0}};
                miss_d   = {LW{1'b0}};
              end else begin
                match_d = match_q + {{(MW-1){1'b0}}, 1'b1};
              end
            end else begin
              match_d = {MW{1'b0}};
            end
          end else begin
            fill_d = fill_q + {{(FW-1){1'b0}}, 1'b1};
          end
        end
        LOCK: begin
          lfsr_d = {lfsr_q[LN-2:0], pred_s};
          if (shiftBit_v != pred_s) begin
            err_d = sat_inc(err_base_s);
            if (miss_q == MISS_M1) begin
              fsm_d    = HUNT;
              locked_d = 1'b0;
              fill_d   = {FW{1'b0}};
              match_d  = {MW{1'b0}};
              miss_d   = {LW{1'b0}};
            end else begin
              miss_d = miss_q + {{(LW-1){1'b0}}, 1'b1};
            end
          end else begin
            miss_d = {LW{1'b0}};
          end
        end
        default: begin
          fsm_d    = HUNT;
          locked_d = 1'b0;
          fill_d   = {FW{1'b0}};
          match_d  = {MW{1'b0}};
          miss_d   = {LW{1'b0}};
        end
      endcase
    end else begin
      fsm_d = fsm_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fsm_q    <= HUNT;
      lfsr_q   <= {LN{1'b0}};
      fill_q   <= {FW{1'b0}};
      match_q  <= {MW{1'b0}};
      miss_q   <= {LW{1'b0}};
      err_q    <= ERR_ZERO;
      locked_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign shiftBit__RDY = 1'b1;
  assign clearErr__RDY = 1'b1;
  assign locked        = locked_q;
  assign errCount      = err_q;
  assign fillCount     = fill_q;

endmodule

// File: tb/tb_lfsr_fib_checker.sv
// Directed bench for lfsr_fib_checker: a bit-history model checked every cycle plus hand-pinned points.
module tb_lfsr_fib_checker;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ena = 1'b0;
  logic        vbit = 1'b0;
  logic        clr = 1'b0;

  logic        rdy_a, crdy_a, locked_a;
  logic [15:0] err_a;
  logic [3:0]  fill_a;
  logic        rdy_b, crdy_b, locked_b;
  logic [3:0]  err_b;
  logic [3:0]  fill_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] TAPS_M = 8'h2D;

  bit ref_bits[512];
  int idx = 0;

  // model state
  bit m_locked;
  int m_fill, m_match, m_miss, m_err_a, m_err_b;
  bit m_hist[$];

  lfsr_fib_checker dut_a (
    .CLK(CLK), .nRST(nRST),
    .shiftBit__ENA(ena), .shiftBit_v(vbit), .shiftBit__RDY(rdy_a),
    .clearErr__ENA(clr), .clearErr__RDY(crdy_a),
    .locked(locked_a), .errCount(err_a), .fillCount(fill_a)
  );

  lfsr_fib_checker #(.ERRW(4)) dut_b (
    .CLK(CLK), .nRST(nRST),
    .shiftBit__ENA(ena), .shiftBit_v(vbit), .shiftBit__RDY(rdy_b),
    .clearErr__ENA(clr), .clearErr__RDY(crdy_b),
    .locked(locked_b), .errCount(err_b), .fillCount(fill_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pred();
    bit p = 1'b0;
    int n = m_hist.size();
    for (int i = 0; i < 8; i++)
      if (TAPS_M[i]) p ^= m_hist[n-1-i];
    return p;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_fill = 0; m_match = 0; m_miss = 0;
    m_err_a = 0; m_err_b = 0;
    m_hist.delete();
  endtask

  task automatic model_apply(input bit e, input bit v, input bit c);
    bit p;
    if (c) begin m_err_a = 0; m_err_b = 0; end
    if (e) begin
      if (!m_locked) begin
        if (m_fill == 8) begin
          if (v == m_pred()) m_match++; else m_match = 0;
        end else m_fill++;
        m_hist.push_back(v);
        if (m_match == 16) begin m_locked = 1'b1; m_miss = 0; end
      end else begin
        p = m_pred();
        m_hist.push_back(p);
        if (v != p) begin
          if (m_err_a < 65535) m_err_a++;
          if (m_err_b < 15) m_err_b++;
          m_miss++;
        end else m_miss = 0;
        if (m_miss == 4) begin m_locked = 1'b0; m_fill = 0; m_match = 0; end
      end
      if (m_hist.size() > 8) void'(m_hist.pop_front());
    end
  endtask

  // Compare both instances against the model on every falling edge
  always @(negedge CLK) begin
    check("locked_a", int'(locked_a), int'(m_locked));
    check("locked_b", int'(locked_b), int'(m_locked));
    check("err_a", int'(err_a), m_err_a);
    check("err_b", int'(err_b), m_err_b);
    check("fill_a", int'(fill_a), m_fill);
    check("fill_b", int'(fill_b), m_fill);
    check("rdy", int'({rdy_a, crdy_a, rdy_b, crdy_b}), 15);
  end

  task automatic step(input bit e, input bit v, input bit c);
    ena = e; vbit = v; clr = c;
    @(posedge CLK); #1;
    model_apply(e, v, c);
  endtask

  task automatic beat(input bit inv, input bit c);
    step(1'b1, ref_bits[idx] ^ inv, c);
    idx++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic hard_reset();
    nRST = 1'b0; model_reset();
    idle(); idle();
    nRST = 1'b1;
  endtask

  initial begin
    logic [7:0] s;
    bit b;
    model_reset();
    s = 8'h01;
    for (int i = 0; i < 512; i++) begin
      b = ^(s & TAPS_M);
      ref_bits[i] = b;
      s = {s[6:0], b};
    end
    check("ref_bit0", int'(ref_bits[0]), 1);
    check("ref_bit1", int'(ref_bits[1]), 1);
    check("ref_bit2", int'(ref_bits[2]), 0);
    check("ref_bit3", int'(ref_bits[3]), 0);

    #2;
    check("reset_locked", int'(locked_a), 0);
    check("reset_err", int'(err_a), 0);
    check("reset_fill", int'(fill_a), 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // clean stream: lock after beat 24
    for (int k = 1; k <= 40; k++) begin
      beat(1'b0, 1'b0);
      if (k == 3)  check("fill_3", int'(fill_a), 3);
      if (k == 8)  check("fill_8", int'(fill_a), 8);
      if (k == 23) check("lock_pre24", int'(locked_a), 0);
      if (k == 24) check("lock_at24", int'(locked_a), 1);
    end
    check("clean_err", int'(err_a), 0);

    // single flipped bit at beat 50
    for (int k = 41; k <= 56; k++) begin
      beat(k == 50, 1'b0);
      if (k == 50) begin
        check("flip_err", int'(err_a), 1);
        check("flip_locked", int'(locked_a), 1);
      end
    end

    // four consecutive inverted bits drop lock
    for (int k = 1; k <= 4; k++) begin
      beat(1'b1, 1'b0);
      if (k == 3) check("miss3_locked", int'(locked_a), 1);
    end
    check("loss_locked", int'(locked_a), 0);
    check("loss_err", int'(err_a), 5);
    check("loss_fill", int'(fill_a), 0);
    for (int k = 1; k <= 24; k++) begin
      beat(1'b0, 1'b0);
      if (k == 23) check("relock_pre", int'(locked_a), 0);
    end
    check("relock", int'(locked_a), 1);
    check("relock_err", int'(err_a), 5);

    // clear coinciding with a mismatch
    beat(1'b1, 1'b1);
    check("clr_mis_a", int'(err_a), 1);
    check("clr_mis_b", int'(err_b), 1);
    beat(1'b0, 1'b0);

    // 20 non-consecutive errors: narrow counter saturates
    for (int k = 0; k < 20; k++) begin
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b0);
    end
    check("sat_a", int'(err_a), 21);
    check("sat_b", int'(err_b), 15);
    check("sat_locked", int'(locked_a), 1);

    // clear alone
    step(1'b0, 1'b0, 1'b1);
    check("clr_a", int'(err_a), 0);
    check("clr_b", int'(err_b), 0);
    check("clr_locked", int'(locked_a), 1);
    beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    check("pre_rst_err", int'(err_a), 2);

    // asynchronous reset between edges
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check("arst_locked", int'(locked_a), 0);
    check("arst_err", int'(err_a), 0);
    idle(); idle();
    nRST = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      beat(1'b0, 1'b0);
      if (k == 23) check("arst_relock_pre", int'(locked_a), 0);
    end
    check("arst_relock", int'(locked_a), 1);

    // gapped stream from the seed: same lock point in beats
    hard_reset();
    idx = 0;
    for (int k = 1; k <= 40; k++) begin
      beat(1'b0, 1'b0);
      idle(); idle();
      if (k == 23) check("gap_pre24", int'(locked_a), 0);
      if (k == 24) check("gap_at24", int'(locked_a), 1);
    end

    // stuck-at-0 input locks onto the all-zero state
    hard_reset();
    for (int k = 1; k <= 24; k++) step(1'b1, 1'b0, 1'b0);
    check("zero_lock", int'(locked_a), 1);
    check("zero_err", int'(err_a), 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
